// File: rtl/exp_stream_host.sv
// exp_stream_host: streams 32-bit operand words into the 1024-bit
// modular-exponentiation core, pulses its start, and streams the result back.
module exp_stream_host (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic [1023:0] exp_x,
  output logic [1023:0] exp_m,
  output logic [1023:0] exp_e,
  output logic [1023:0] exp_r,
  output logic [1023:0] exp_r2,
  output logic [31:0]   exp_lene,
  output logic          exp_start,
  input  logic [1023:0] exp_result,
  input  logic          exp_done
);

  localparam int unsigned W   = 32;
  localparam int unsigned OPW = 1024;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4
  } state_t;

  state_t         state_q;
  logic [4:0]     cnt_q;
  logic [2:0]     idx_q;
  logic [OPW-1:0] x_q, m_q, e_q, r_q, r2_q, res_q;
  logic [W-1:0]   lene_q;
  logic           in_ready_q, out_valid_q, out_last_q, start_q, busy_q;
  logic           in_hs, out_hs;

  assign in_hs  = in_valid && in_ready_q;
  assign out_hs = out_valid_q && out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = res_q[W-1:0];
  assign busy      = busy_q;
  assign exp_start = start_q;
  assign exp_x     = x_q;
  assign exp_m     = m_q;
  assign exp_e     = e_q;
  assign exp_r     = r_q;
  assign exp_r2    = r2_q;
  assign exp_lene  = lene_q;

  // Job sequencer: operand load, core start/done handshake, result unload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      idx_q       <= 3'd0;
      x_q         <= '0;
      m_q         <= '0;
      e_q         <= '0;
      r_q         <= '0;
      r2_q        <= '0;
      res_q       <= '0;
      lene_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          state_q    <= S_LOAD;
          in_ready_q <= 1'b1;
        end
        S_LOAD: begin
          if (in_hs) begin
            case (idx_q)
              3'd0:    x_q    <= {in_data, x_q[OPW-1:W]};
              3'd1:    m_q    <= {in_data, m_q[OPW-1:W]};
              3'd2:    e_q    <= {in_data, e_q[OPW-1:W]};
              3'd3:    r_q    <= {in_data, r_q[OPW-1:W]};
              3'd4:    r2_q   <= {in_data, r2_q[OPW-1:W]};
              3'd5:    lene_q <= in_data;
              default: ;
            endcase
            if (idx_q == 3'd5) begin
              state_q    <= S_START;
              in_ready_q <= 1'b0;
              start_q    <= 1'b1;
              busy_q     <= 1'b1;
              cnt_q      <= 5'd0;
              idx_q      <= 3'd0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == 5'd31) idx_q <= idx_q + 3'd1;
            end
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (exp_done) begin
            res_q       <= exp_result;
            cnt_q       <= 5'd0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            state_q     <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (out_hs) begin
            res_q      <= {W'(0), res_q[OPW-1:W]};
            cnt_q      <= cnt_q + 5'd1;
            out_last_q <= (cnt_q == 5'd30);
            if (cnt_q == 5'd31) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_stream_host.sv
// Directed bench for exp_stream_host with a fixed-latency core model.
module tb_exp_stream_host;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic [1023:0] exp_x, exp_m, exp_e, exp_r, exp_r2;
  logic [31:0]   exp_lene;
  logic          exp_start;
  logic [1023:0] exp_result;
  logic          exp_done = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int core_cnt = 0;

  exp_stream_host dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy),
    .exp_x(exp_x), .exp_m(exp_m), .exp_e(exp_e), .exp_r(exp_r), .exp_r2(exp_r2),
    .exp_lene(exp_lene), .exp_start(exp_start),
    .exp_result(exp_result), .exp_done(exp_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: done pulse 50 cycles after start; ignores host reset.
  always @(posedge clk) begin
    exp_done <= 1'b0;
    if (exp_start) core_cnt <= 50;
    else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) exp_done <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int w;
    w = -1;
    for (int k = 0; k < 32; k++)
      if (w < 0 && obs[k*32 +: 32] !== exp[k*32 +: 32]) w = k;
    if (w < 0) w = 0;
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: word %0d got %h want %h", tag, w, obs[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  function automatic logic [1023:0] build_op(input logic [31:0] base);
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[k*32 +: 32] = base + 32'(k);
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_out_data"},  out_data,       32'd0);
    chk({tag, "_start"},     32'(exp_start), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_lene"},      exp_lene,       32'd0);
    chkw({tag, "_x"},  exp_x,  '0);
    chkw({tag, "_r2"}, exp_r2, '0);
  endtask

  // Release reset mid-cycle; IDLE for one cycle, then LOAD.
  task automatic release_reset();
    reset = 1'b0;
    chk("rel_ready_first", 32'(in_ready), 32'd0);
    step();
    chk("rel_ready_second", 32'(in_ready), 32'd1);
  endtask

  task automatic send_frame(input logic [31:0] base, input bit gaps, output int first_cyc);
    int n;
    bit acc;
    first_cyc = -1;
    for (int i = 0; i < 161; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        step();
        repeat ($urandom_range(0, 2)) step();
      end
      in_data  = base + 32'(i);
      in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 1000) begin
        acc = in_ready;
        step();
        n++;
      end
      if (!acc) begin
        chk("in_hs_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      if (i == 0) first_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_regs(input logic [31:0] base);
    chkw("reg_x",  exp_x,  build_op(base));
    chkw("reg_m",  exp_m,  build_op(base + 32'd32));
    chkw("reg_e",  exp_e,  build_op(base + 32'd64));
    chkw("reg_r",  exp_r,  build_op(base + 32'd96));
    chkw("reg_r2", exp_r2, build_op(base + 32'd128));
    chk("reg_lene", exp_lene, base + 32'd160);
  endtask

  // Called in the cycle right after the lene handshake.
  task automatic after_frame(input logic [31:0] base);
    chk("start_high", 32'(exp_start), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("start_one_cycle", 32'(exp_start), 32'd0);
    chk("wait_ready_low", 32'(in_ready), 32'd0);
    check_regs(base);
  endtask

  task automatic recv_result(input bit stall, output int last_cyc);
    int n;
    out_ready = 1'b0;
    last_cyc = -1;
    n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    chk("out_valid_rise", 32'(out_valid), 32'd1);
    if (!out_valid) return;
    if (stall) begin
      for (int s = 0; s < 5; s++) begin
        chk("stall_data", out_data, 32'h100);
        chk("stall_valid", 32'(out_valid), 32'd1);
        step();
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      n = 0;
      while (!out_valid && n < 50) begin
        step();
        n++;
      end
      chk("out_word", out_data, 32'h100 + 32'(k));
      chk("out_last", 32'(out_last), (k == 31) ? 32'd1 : 32'd0);
      step();
    end
    last_cyc = cyc;
    out_ready = 1'b0;
    chk("post_ready", 32'(in_ready), 32'd1);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int fa, fb, la, lx;
    for (int k = 0; k < 32; k++) exp_result[k*32 +: 32] = 32'h100 + 32'(k);
    reset     = 1'b1;
    in_data   = 32'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Power-on reset
    step();
    step();
    chk_all_zero("por");
    release_reset();

    // Partial load, then asynchronous reset mid-cycle
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'hDEAD0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("partial_top", exp_x[1023:992], 32'hDEAD0004);
    #2 reset = 1'b1;
    #1 chk_all_zero("async");
    step();
    release_reset();

    // Straight load of 0x00..0xA0, result with output stall
    send_frame(32'h0, 1'b0, fa);
    after_frame(32'h0);
    chk("x_lo", exp_x[31:0], 32'h0);
    chk("x_hi", exp_x[1023:992], 32'h1F);
    chk("r2_lo", exp_r2[31:0], 32'h80);
    chk("lene", exp_lene, 32'hA0);
    recv_result(1'b1, lx);

    // Same frame with input gaps
    send_frame(32'h0, 1'b1, fa);
    after_frame(32'h0);
    recv_result(1'b0, lx);

    // Reset during WAIT; late exp_done must be ignored
    send_frame(32'h500, 1'b0, fa);
    after_frame(32'h500);
    repeat (20) step();
    reset = 1'b1;
    #2 chk("wait_rst_x", exp_x[31:0], 32'h0);
    step();
    release_reset();
    for (int i = 0; i < 45; i++) begin
      chk("rst_no_valid", 32'(out_valid), 32'd0);
      chk("rst_in_load", 32'(in_ready), 32'd1);
      step();
    end
    send_frame(32'h2000, 1'b0, fa);
    after_frame(32'h2000);
    recv_result(1'b0, lx);

    // Back-to-back frames with in_valid held high
    fork
      begin
        send_frame(32'h3000, 1'b0, fa);
        send_frame(32'h4000, 1'b0, fb);
      end
      begin
        int n;
        n = 0;
        while (!exp_start && n < 400) begin
          step();
          n++;
        end
        chk("b2b_start", 32'(exp_start), 32'd1);
        step();
        n = 0;
        while (!out_valid && n < 200) begin
          chkw("b2b_x_held", exp_x, build_op(32'h3000));
          chk("b2b_ready_low", 32'(in_ready), 32'd0);
          step();
          n++;
        end
        recv_result(1'b0, la);
      end
    join
    chk("b2b_gap", 32'(fb), 32'(la + 1));
    after_frame(32'h4000);
    recv_result(1'b0, lx);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
